io_input_conditioner: RTL and testbench

Synchronises, debounces and edge-detects the board's slide switches and push-buttons, and presents them to the RV32I core as a 32-bit GPIO input word. It also provides a change flag that reads clear, one-cycle press pulses, and a debounced CPU reset derived from KEY[0]. It sits between the top-level SW/KEY pins and the core's GPIO_IN port, on the input side of the board I/O path.

---
 rtl/io_pkg.sv | 16 +
 rtl/debounce_bit.sv | 67 ++++++
 rtl/io_input_conditioner.sv | 81 ++++++++
 tb/tb_io_input_conditioner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the board input conditioner.
package io_pkg;

  typedef enum logic {
    STABLE,
    SETTLING
  } dbnc_state_t;

  localparam int NUM_SW        = 18;
  localparam int NUM_KEY       = 4;
  localparam int NUM_IN        = NUM_SW + NUM_KEY;
  localparam int KEY_LSB       = 0;
  localparam int SW_LSB        = 4;
  localparam int GPIO_IN_PAD_W = 10;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: accepts a new level only after it has been held
// for DEBOUNCE_CYCLES consecutive cycles, pulsing `update` when it does.
module debounce_bit
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sync,
  output logic db,
  output logic update
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  dbnc_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      db      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db      <= db_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db;
    case (state_q)
      STABLE: begin
        if (in_sync != db) begin
          state_d = SETTLING;
          cnt_d   = '0;
        end
      end
      SETTLING: begin
        // A bounce back to the accepted level abandons the settle outright.
        if (in_sync == db) begin
          state_d = STABLE;
        end else if (at_last) begin
          db_d    = in_sync;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  always_comb begin
    update = (state_q == SETTLING) && (in_sync != db) && at_last;
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Synchronises and debounces SW/KEY, builds the GPIO input word, and derives
// press pulses, a read-clear change flag and a debounced CPU reset.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] sw_raw,
  input  logic [3:0]  key_raw_n,
  input  logic        rd_en,
  output logic [31:0] gpio_in,
  output logic [3:0]  key_press,
  output logic        changed,
  output logic        cpu_rst
);

  logic [NUM_IN-1:0]  raw_in;
  logic [NUM_IN-1:0]  sync1;
  logic [NUM_IN-1:0]  sync2;
  logic [NUM_IN-1:0]  db_all;
  logic [NUM_IN-1:0]  update_all;
  logic [NUM_KEY-1:0] key_db;
  logic [NUM_KEY-1:0] key_db_q;
  logic [NUM_SW-1:0]  sw_db;

  // Keys are inverted up front so every bit downstream is active-high.
  assign raw_in = {sw_raw, ~key_raw_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_dbnc
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_dbnc (
      .clk    (clk),
      .rst    (rst),
      .in_sync(sync2[i]),
      .db     (db_all[i]),
      .update (update_all[i])
    );
  end

  assign key_db = db_all[KEY_LSB +: NUM_KEY];
  assign sw_db  = db_all[SW_LSB +: NUM_SW];

  always_ff @(posedge clk) begin
    if (rst) begin
      key_db_q <= '0;
    end else begin
      key_db_q <= key_db;
    end
  end

  // A fresh update outranks a same-cycle read so no change is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      changed <= 1'b0;
    end else if (|update_all) begin
      changed <= 1'b1;
    end else if (rd_en) begin
      changed <= 1'b0;
    end
  end

  assign gpio_in   = {{GPIO_IN_PAD_W{1'b0}}, sw_db, key_db};
  assign key_press = key_db & ~key_db_q;
  assign cpu_rst   = rst | key_db[0];

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_io_input_conditioner;

  logic        clk;
  logic        rst;
  logic [17:0] sw_raw;
  logic [3:0]  key_raw_n;
  logic        rd_en;
  logic [31:0] gpio_in;
  logic [3:0]  key_press;
  logic        changed;
  logic        cpu_rst;

  int vector_count = 0;
  int miss_count   = 0;

  io_input_conditioner #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_raw   (sw_raw),
    .key_raw_n(key_raw_n),
    .rd_en    (rd_en),
    .gpio_in  (gpio_in),
    .key_press(key_press),
    .changed  (changed),
    .cpu_rst  (cpu_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [17:0] sw, input logic [3:0] keyn, input logic rd);
    sw_raw    = sw;
    key_raw_n = keyn;
    rd_en     = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pulseRead();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset with everything off and released
    rst = 1'b1;
    applyStimulus(18'h0, 4'hF, 1'b0);
    tick(3);
    checkOutput("rst_gpio", gpio_in, 32'h0);
    checkOutput("rst_press", 32'(key_press), 32'h0);
    checkOutput("rst_changed", 32'(changed), 32'h0);
    checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    rst = 1'b0;
    tick(1);
    checkOutput("post_rst_cpu_rst", 32'(cpu_rst), 32'h0);
    checkOutput("post_rst_gpio", gpio_in, 32'h0);

    // SW[3] -> gpio bit 7 after edge 6
    applyStimulus(18'h00008, 4'hF, 1'b0);
    tick(6);
    checkOutput("sw3_edge5_gpio", gpio_in, 32'h0);
    checkOutput("sw3_edge5_changed", 32'(changed), 32'h0);
    tick(1);
    checkOutput("sw3_edge6_gpio", gpio_in, 32'h80);
    checkOutput("sw3_edge6_changed", 32'(changed), 32'h1);
    pulseRead();
    checkOutput("sw3_read_changed", 32'(changed), 32'h0);
    checkOutput("sw3_read_gpio", gpio_in, 32'h80);

    // SW[0] glitch of 3 raw cycles is rejected
    applyStimulus(18'h00009, 4'hF, 1'b0);
    tick(3);
    applyStimulus(18'h00008, 4'hF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("glitch_gpio", gpio_in, 32'h80);
      checkOutput("glitch_changed", 32'(changed), 32'h0);
    end

    // KEY[2] press: one-cycle pulse, release gives no pulse
    applyStimulus(18'h00008, 4'b1011, 1'b0);
    tick(6);
    checkOutput("key2_edge5_gpio", gpio_in, 32'h80);
    checkOutput("key2_edge5_press", 32'(key_press), 32'h0);
    tick(1);
    checkOutput("key2_edge6_gpio", gpio_in, 32'h84);
    checkOutput("key2_edge6_press", 32'(key_press), 32'h4);
    checkOutput("key2_edge6_changed", 32'(changed), 32'h1);
    tick(1);
    checkOutput("key2_edge7_press", 32'(key_press), 32'h0);
    checkOutput("key2_edge7_gpio", gpio_in, 32'h84);
    pulseRead();
    applyStimulus(18'h00008, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checkOutput("key2_release_press", 32'(key_press), 32'h0);
    end
    checkOutput("key2_release_gpio", gpio_in, 32'h80);
    checkOutput("key2_release_changed", 32'(changed), 32'h1);
    pulseRead();

    // KEY[0] held 20 cycles drives cpu_rst
    applyStimulus(18'h00008, 4'b1110, 1'b0);
    tick(6);
    checkOutput("key0_edge5_cpu_rst", 32'(cpu_rst), 32'h0);
    tick(1);
    checkOutput("key0_edge6_cpu_rst", 32'(cpu_rst), 32'h1);
    checkOutput("key0_edge6_gpio", gpio_in, 32'h81);
    checkOutput("key0_edge6_press", 32'(key_press), 32'h1);
    tick(13);
    checkOutput("key0_held_cpu_rst", 32'(cpu_rst), 32'h1);
    applyStimulus(18'h00008, 4'hF, 1'b0);
    tick(6);
    checkOutput("key0_rel5_cpu_rst", 32'(cpu_rst), 32'h1);
    tick(1);
    checkOutput("key0_rel6_cpu_rst", 32'(cpu_rst), 32'h0);
    pulseRead();
    checkOutput("key0_cleared", 32'(changed), 32'h0);

    // rd_en in the same cycle as an update strobe: set wins
    applyStimulus(18'h0000A, 4'hF, 1'b0);
    tick(6);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    checkOutput("coinc_changed", 32'(changed), 32'h1);
    checkOutput("coinc_gpio", gpio_in, 32'hA0);
    pulseRead();
    checkOutput("coinc_clear", 32'(changed), 32'h0);

    // rst at edge 4 of a SW[5] settle abandons it; re-debounce after release
    applyStimulus(18'h0002A, 4'hF, 1'b0);
    tick(4);
    rst = 1'b1;
    tick(1);
    checkOutput("midrst_gpio", gpio_in, 32'h0);
    checkOutput("midrst_cpu_rst", 32'(cpu_rst), 32'h1);
    checkOutput("midrst_changed", 32'(changed), 32'h0);
    rst = 1'b0;
    tick(6);
    checkOutput("midrst_edge5_gpio9", 32'(gpio_in[9]), 32'h0);
    checkOutput("midrst_edge5_gpio", gpio_in, 32'h0);
    tick(1);
    checkOutput("midrst_edge6_gpio9", 32'(gpio_in[9]), 32'h1);
    checkOutput("midrst_edge6_gpio", gpio_in, 32'h2A0);
    checkOutput("midrst_edge6_changed", 32'(changed), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
